// File: rtl/sram_arbiter.sv
// Shares one external SRAM between the CPU data port and the VGA fetch port,
// one transaction at a time, with VGA priority in active video and a CPU starvation guard.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  vga_state,
    input  logic        cpu_req,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_sel,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        vga_req,
    input  logic [31:0] vga_addr,
    output logic        vga_ack,
    output logic [31:0] vga_rdata,
    output logic        err,
    output logic        sram_read,
    output logic        sram_write,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic [3:0]  sram_byte_sel,
    input  logic        sram_busy,
    input  logic        sram_data_en,
    input  logic [31:0] sram_rdata,
    // Handshake: each req is held until its one-cycle ack; dbg_state 0=IDLE 1=ISSUE 2=WAIT 3=RESP
    output logic [1:0]  dbg_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_VGA = 2'd2} owner_t;

    state_t        state;
    owner_t        owner;
    logic          wen;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_cpu;
    logic          grant_vga;
    logic          tmo_hit;

    assign dbg_state = state;
    // High during the last cycle allowed before the transaction is abandoned.
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    always_comb begin
        grant_cpu = 1'b0;
        grant_vga = 1'b0;
        if (cpu_req && starve_cnt == STARVE_MAX) grant_cpu = 1'b1;
        else if (vga_state == 2'd2 && vga_req)   grant_vga = 1'b1;
        else if (cpu_req)                        grant_cpu = 1'b1;
        else if (vga_req)                        grant_vga = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            owner         <= OWN_NONE;
            wen           <= 1'b0;
            starve_cnt    <= '0;
            tmo_cnt       <= '0;
            cpu_ack       <= 1'b0;
            vga_ack       <= 1'b0;
            err           <= 1'b0;
            cpu_rdata     <= '0;
            vga_rdata     <= '0;
            sram_read     <= 1'b0;
            sram_write    <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_byte_sel <= '0;
        end else begin
            cpu_ack <= 1'b0;
            vga_ack <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cpu_req) starve_cnt <= '0;
                    if (grant_cpu) begin
                        owner         <= OWN_CPU;
                        wen           <= cpu_wen;
                        sram_addr     <= cpu_addr;
                        sram_wdata    <= cpu_wdata;
                        sram_byte_sel <= cpu_byte_sel;
                        sram_read     <= !cpu_wen;
                        sram_write    <= cpu_wen;
                        starve_cnt    <= '0;
                        state         <= ISSUE;
                    end else if (grant_vga) begin
                        owner         <= OWN_VGA;
                        wen           <= 1'b0;
                        sram_addr     <= vga_addr;
                        sram_wdata    <= '0;
                        sram_byte_sel <= 4'b1111;
                        sram_read     <= 1'b1;
                        sram_write    <= 1'b0;
                        if (cpu_req && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (tmo_hit) begin
                        sram_read  <= 1'b0;
                        sram_write <= 1'b0;
                        err        <= 1'b1;
                        if (owner == OWN_CPU) begin cpu_ack <= 1'b1; cpu_rdata <= '0; end
                        else begin vga_ack <= 1'b1; vga_rdata <= '0; end
                        state <= RESP;
                    end else if (!sram_busy) begin
                        sram_read  <= 1'b0;
                        sram_write <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (sram_data_en) begin
                        if (owner == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!wen) cpu_rdata <= sram_rdata;
                        end else begin
                            vga_ack   <= 1'b1;
                            vga_rdata <= sram_rdata;
                        end
                        state <= RESP;
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                        if (owner == OWN_CPU) begin cpu_ack <= 1'b1; cpu_rdata <= '0; end
                        else begin vga_ack <= 1'b1; vga_rdata <= '0; end
                        state <= RESP;
                    end
                end
                RESP: begin
                    owner   <= OWN_NONE;
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a transaction-schedule model predicts every output per cycle,
// and hand-computed literals pin latency, grant order, timeout and reset behaviour.
module tb_sram_arbiter;
    localparam int STARVE_LIMIT = 8;
    localparam int TIMEOUT      = 255;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [1:0] vga_state = '0;
    logic cpu_req = 1'b0, cpu_wen = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0] cpu_byte_sel = '0;
    logic cpu_ack;
    logic [31:0] cpu_rdata;
    logic vga_req = 1'b0;
    logic [31:0] vga_addr = '0;
    logic vga_ack;
    logic [31:0] vga_rdata;
    logic err, sram_read, sram_write;
    logic [31:0] sram_addr, sram_wdata;
    logic [3:0] sram_byte_sel;
    logic sram_busy = 1'b0, sram_data_en = 1'b0;
    logic [31:0] sram_rdata = '0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nrst(nrst), .vga_state(vga_state),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byte_sel(cpu_byte_sel), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .err(err), .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_byte_sel(sram_byte_sel), .sram_busy(sram_busy),
        .sram_data_en(sram_data_en), .sram_rdata(sram_rdata), .dbg_state(dbg_state)
    );

    int n_tests = 0, n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a ^ 32'hC0DE_0000) + 32'h1111;
    endfunction

    // Scenario knobs: busy cycles before accept, and data_en delay after accept (0 = never).
    int sc_busy = 0, sc_lat = 1;

    // Model: one record per granted transaction, expressed as a cycle schedule.
    int cyc, free_at, starve;
    bit t_valid, t_tmo, t_cpu, t_wen;
    int t_g, t_b, t_l, t_ack;
    logic [31:0] t_addr, t_wdata;
    logic [3:0] t_bsel;
    logic [31:0] e_cpu_rdata, e_vga_rdata;

    always @(posedge clk or negedge nrst) begin : model
        bit pick_cpu, pick_vga;
        if (!nrst) begin
            cyc = 0; free_at = 0; starve = 0; t_valid = 0;
            e_cpu_rdata = '0; e_vga_rdata = '0;
        end else begin
            if (cyc >= free_at) begin
                pick_cpu = 0; pick_vga = 0;
                if (cpu_req && starve == STARVE_LIMIT) pick_cpu = 1;
                else if (vga_state == 2'd2 && vga_req) pick_vga = 1;
                else if (cpu_req) pick_cpu = 1;
                else if (vga_req) pick_vga = 1;
                if (!cpu_req || pick_cpu) starve = 0;
                else if (pick_vga && starve < STARVE_LIMIT) starve++;
                if (pick_cpu || pick_vga) begin
                    t_valid = 1; t_g = cyc; t_b = sc_busy; t_l = sc_lat; t_cpu = pick_cpu;
                    t_wen   = pick_cpu ? cpu_wen : 1'b0;
                    t_addr  = pick_cpu ? cpu_addr : vga_addr;
                    t_wdata = cpu_wdata;
                    t_bsel  = pick_cpu ? cpu_byte_sel : 4'hF;
                    t_tmo   = (t_l == 0) || (1 + t_b + t_l > TIMEOUT);
                    t_ack   = t_tmo ? t_g + TIMEOUT + 1 : t_g + 2 + t_b + t_l;
                    free_at = t_ack + 1;
                end
            end
            cyc++;
            if (t_valid && cyc == t_ack) begin
                if (t_tmo) begin
                    if (t_cpu) e_cpu_rdata = '0; else e_vga_rdata = '0;
                end else if (!t_wen) begin
                    if (t_cpu) e_cpu_rdata = mem(t_addr); else e_vga_rdata = mem(t_addr);
                end
            end
        end
    end

    // SRAM responder follows the scripted schedule; garbage on sram_rdata outside data_en.
    always @(posedge clk) begin
        #1;
        sram_busy    = nrst && t_valid && cyc >= t_g + 1 && cyc <= t_g + t_b;
        sram_data_en = nrst && t_valid && !t_tmo && cyc == t_g + 1 + t_b + t_l;
        sram_rdata   = sram_data_en ? mem(t_addr) : $urandom();
    end

    always @(negedge clk) begin : compare
        bit in_txn, strobe;
        logic [1:0] es;
        if (nrst && chk_on) begin
            in_txn = t_valid && cyc >= t_g + 1 && cyc <= t_ack;
            strobe = t_valid && cyc >= t_g + 1 && cyc <= t_g + 1 + t_b && cyc < t_ack;
            es = !in_txn ? 2'd0 : (cyc == t_ack) ? 2'd3 : strobe ? 2'd1 : 2'd2;
            chk("cpu_ack", cpu_ack, t_valid && t_cpu && cyc == t_ack);
            chk("vga_ack", vga_ack, t_valid && !t_cpu && cyc == t_ack);
            chk("err", err, t_valid && t_tmo && cyc == t_ack);
            chk("sram_read", sram_read, strobe && !t_wen);
            chk("sram_write", sram_write, strobe && t_wen);
            chk("state", dbg_state, es);
            chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
            chk("vga_rdata", vga_rdata, e_vga_rdata);
            if (in_txn) begin
                chk("sram_addr", sram_addr, t_addr);
                chk("sram_byte_sel", sram_byte_sel, t_bsel);
                if (t_wen) chk("sram_wdata", sram_wdata, t_wdata);
            end
        end
    end

    // Observation log: grant order (1 = CPU, 0 = VGA), strobe cycles, errored acks.
    logic [0:0] log_q[$];
    logic [0:0] exp_q[$];
    int strobe_cnt = 0, err_cnt = 0;
    always @(negedge clk) begin
        if (nrst) begin
            if (cpu_ack) log_q.push_back(1'b1);
            if (vga_ack) log_q.push_back(1'b0);
            if (sram_read || sram_write) strobe_cnt++;
            if (err && (cpu_ack || vga_ack)) err_cnt++;
        end
    end

    task automatic check_log();
        chk("ack_order_len", log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk($sformatf("ack_order[%0d]", i), log_q[i], exp_q[i]);
    endtask

    task automatic cpu_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] bsel, output int lat);
        bit done;
        cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_byte_sel = bsel;
        cpu_req = 1'b1; lat = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (cpu_ack) done = 1;
            else begin
                lat++;
                if (lat > 400) begin
                    n_tests++; n_fail++;
                    $display("FAIL cpu_ack_wait: no ack after %0d cycles, required one", lat);
                    done = 1;
                end
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    int vga_seq = 0;
    task automatic vga_stream(input int n, output int lat);
        bit done;
        lat = 0;
        for (int i = 0; i < n; i++) begin
            vga_addr = 32'h1000 + 32'(vga_seq * 4);
            vga_seq++;
            vga_req = 1'b1; lat = 0; done = 0;
            while (!done) begin
                @(negedge clk);
                if (vga_ack) done = 1;
                else begin
                    lat++;
                    if (lat > 400) begin
                        n_tests++; n_fail++;
                        $display("FAIL vga_ack_wait: no ack after %0d cycles, required one", lat);
                        done = 1;
                    end
                end
            end
            @(posedge clk); #1;
            vga_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat, lat2;
    initial begin
        repeat (3) @(posedge clk);
        #3 nrst = 1'b1;
        @(negedge clk);
        chk("rst_cpu_ack", cpu_ack, 0);      chk("rst_vga_ack", vga_ack, 0);
        chk("rst_err", err, 0);              chk("rst_sram_read", sram_read, 0);
        chk("rst_sram_write", sram_write, 0); chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_vga_rdata", vga_rdata, 0);  chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0); chk("rst_byte_sel", sram_byte_sel, 0);
        chk("rst_state", dbg_state, 0);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Minimum-latency CPU read.
        sc_busy = 0; sc_lat = 1; strobe_cnt = 0; err_cnt = 0;
        cpu_txn(1'b0, 32'h10, 32'h0, 4'hF, lat);
        chk("rd_latency", lat, 3);
        chk("rd_strobe_cycles", strobe_cnt, 1);
        chk("rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("rd_err", err_cnt, 0);

        // CPU write stalled by 5 busy cycles.
        sc_busy = 5; strobe_cnt = 0;
        cpu_txn(1'b1, 32'h20, 32'h12345678, 4'b0011, lat);
        sc_busy = 0;
        chk("wr_latency", lat, 8);
        chk("wr_strobe_cycles", strobe_cnt, 6);
        chk("wr_err", err_cnt, 0);
        chk("wr_keeps_rdata", cpu_rdata, 32'hDEADBEEF);

        // Active video contention: 8 VGA grants, then the CPU, then VGA again.
        vga_state = 2'd2; log_q.delete(); exp_q.delete();
        repeat (8) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        fork
            cpu_txn(1'b0, 32'h30, 32'h0, 4'hF, lat);
            vga_stream(10, lat2);
        join
        check_log();
        chk("starve_cpu_rdata", cpu_rdata, 32'hC0DE1141);

        // Blanking contention: CPU wins first.
        vga_state = 2'd0; log_q.delete(); exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        fork
            cpu_txn(1'b0, 32'h34, 32'h0, 4'hF, lat);
            vga_stream(1, lat2);
        join
        check_log();

        // VGA read with no data_en: timeout.
        vga_state = 2'd2; sc_lat = 0; err_cnt = 0;
        vga_stream(1, lat2);
        chk("tmo_latency", lat2, TIMEOUT + 1);
        chk("tmo_err_with_ack", err_cnt, 1);
        @(negedge clk);
        chk("tmo_back_idle", dbg_state, 0);
        chk("tmo_vga_rdata", vga_rdata, 0);
        sc_lat = 1;
        @(posedge clk); #1;

        // Reset during WAIT.
        sc_lat = 20;
        cpu_wen = 1'b0; cpu_addr = 32'h40; cpu_byte_sel = 4'hF; cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_state", dbg_state, 2);
        #1 nrst = 1'b0; cpu_req = 1'b0;
        #1;
        chk("async_rst_state", dbg_state, 0);
        chk("async_rst_read", sram_read, 0);
        chk("async_rst_write", sram_write, 0);
        chk("async_rst_cpu_ack", cpu_ack, 0);
        chk("async_rst_vga_ack", vga_ack, 0);
        sc_lat = 1;
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        log_q.delete();
        repeat (30) @(posedge clk);
        #1;
        chk("no_ack_after_reset", log_q.size(), 0);
        chk("rdata_cleared_by_reset", cpu_rdata, 0);
        cpu_txn(1'b0, 32'h10, 32'h0, 4'hF, lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", cpu_rdata, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
